// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 codes and FSM states.
package riscv_mem_pkg;

  // RV32 load/store width codes carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request sequencing: accept in IDLE, optional wait states, one RAM edge, one response cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables/replication, load extension, width faults.
module mem_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  // Addressed byte/half moved down to bit 0 so extension always looks at the low bits
  logic [31:0] shifted;
  assign shifted = raw >> {lane, 3'b000};

  // Decode access width: lane enables, replicated store data, extended load data, fault flags
  always_comb begin
    be        = 4'h0;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        misalign  = lane[0];
      end
      F3_W: begin
        be        = 4'hF;
        rdata_ext = raw;
        misalign  = (lane != 2'b00);
      end
      // Unsigned widths exist only for loads
      F3_BU: begin
        rdata_ext = {24'h0, shifted[7:0]};
        illegal   = we;
      end
      F3_HU: begin
        rdata_ext = {16'h0, shifted[15:0]};
        misalign  = lane[0];
        illegal   = we;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 data memory with load/store front end, valid/ready request port and optional wait states.
module data_mem_lsu
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rd_word_reg;
  logic [31:0] held_rdata_reg;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             out_of_range;
  logic             fault;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic             misalign;
  logic             illegal;
  logic [31:0]      resp_data;

  assign req_ready    = (state_reg == IDLE);
  assign accept       = req_valid && req_ready;
  assign idx          = addr_reg[IDX_W+1:2];
  assign lane         = addr_reg[1:0];
  assign out_of_range = |(addr_reg >> (IDX_W + 2));
  assign fault        = misalign || illegal || out_of_range;

  mem_align u_align (
    .we        (we_reg),
    .funct3    (funct3_reg),
    .lane      (lane),
    .wdata     (wdata_reg),
    .raw       (rd_word_reg),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  // State and wait-counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: wait states are skipped entirely when none are configured
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = ACCESS;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on acceptance; held stable until the response cycle ends
  always_ff @(posedge clock) begin
    if (reset) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

  // Byte-lane RAM write; reset on the same edge wins so an aborted store never lands
  always_ff @(posedge clock) begin
    if (!reset && state_reg == ACCESS && we_reg && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Registered RAM read; extension happens on the registered word during RESP
  always_ff @(posedge clock) begin
    if (state_reg == ACCESS) rd_word_reg <= mem[idx];
  end

  // Stores and faults return zero; loads return the extended lane
  assign resp_data = (we_reg || fault) ? 32'h0 : rdata_ext;

  // Keep the last response data visible between responses
  always_ff @(posedge clock) begin
    if (reset)                  held_rdata_reg <= 32'h0;
    else if (state_reg == RESP) held_rdata_reg <= resp_data;
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_fault = rsp_valid && fault;
  assign rsp_rdata = rsp_valid ? resp_data : held_rdata_reg;

endmodule
